// File: rtl/tp84_pkg.sv
// -----------------------------------------------------------------------------
// tp84_pkg
// Shared definitions for the TP84 sprite line buffer slice.
//   PIX_W_DEF   : default pixel width (palette index plus priority bits)
//   TRANSP_DEF  : default transparent / clear pixel value
//   LB_ADDR_W   : line buffer address width (256 x positions)
//   lb_state_t  : line buffer control states
// -----------------------------------------------------------------------------
package tp84_pkg;

    localparam int unsigned PIX_W_DEF  = 8;
    localparam int unsigned TRANSP_DEF = 0;
    localparam int unsigned LB_ADDR_W  = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lb_state_t;

endpackage

// File: rtl/linebuf_dpram.sv
// -----------------------------------------------------------------------------
// linebuf_dpram
// 2**ADDR_W x PIX_W dual-port synchronous RAM for one line buffer bank.
// Port A reads with a registered output (updated only when enabled);
// port B writes. Both ports run on the same clock.
//   i_clk      : clock
//   i_a_en     : port A read enable
//   i_a_addr   : port A address
//   o_a_rdata  : port A registered read data (read-before-write)
//   i_b_we     : port B write enable
//   i_b_addr   : port B address
//   i_b_wdata  : port B write data
// -----------------------------------------------------------------------------
module linebuf_dpram #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_a_en,
    input  logic [ADDR_W-1:0] i_a_addr,
    output logic [PIX_W-1:0]  o_a_rdata,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [PIX_W-1:0]  i_b_wdata
);

    logic [PIX_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [PIX_W-1:0] r_a_rdata;

    always_ff @(posedge i_clk) begin
        if (i_a_en) begin
            r_a_rdata <= r_mem[i_a_addr];
        end
        if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_wdata;
        end
    end

    assign o_a_rdata = r_a_rdata;

endmodule

// File: rtl/tp84_sprite_linebuf.sv
// -----------------------------------------------------------------------------
// tp84_sprite_linebuf
// Double-buffered sprite line buffer. The sprite engine fills the write bank
// while the mixer reads (and clears) the display bank; the banks swap when the
// horizontal counter wraps from 511 to 128. First opaque write per x wins.
//   i_clk       : master clock
//   i_reset     : synchronous active-high reset
//   i_cen       : pixel clock enable (never high two clk in a row)
//   i_h_pos     : h128..h1 of the horizontal counter
//   i_n_h256    : horizontal counter bit 8, 1 = visible half
//   i_wr_valid  : sprite write request
//   o_wr_ready  : write accepted when valid & ready
//   i_wr_x      : write x position
//   i_wr_pix    : write pixel
//   o_pix_out   : registered sprite pixel to the mixer
//   o_init_busy : high while the post-reset clear sweep runs
// -----------------------------------------------------------------------------
module tp84_sprite_linebuf
    import tp84_pkg::*;
#(
    parameter int unsigned     PIX_W  = PIX_W_DEF,
    parameter logic [PIX_W-1:0] TRANSP = PIX_W'(TRANSP_DEF)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cen,
    input  logic [7:0]       i_h_pos,
    input  logic             i_n_h256,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [7:0]       i_wr_x,
    input  logic [PIX_W-1:0] i_wr_pix,
    output logic [PIX_W-1:0] o_pix_out,
    output logic             o_init_busy
);

    // Control state
    lb_state_t        r_state;
    logic [7:0]       r_sweep;
    logic             r_init_busy;

    // Bank swap tracking
    logic             r_bank_sel;
    logic             r_prev_h256;
    logic             r_swap_d1;

    // Write pipeline
    logic             r_s1_v;
    logic [7:0]       r_s1_x;
    logic [PIX_W-1:0] r_s1_pix;
    logic             r_s1_bank;

    logic             r_s2_v;
    logic             r_s2_we;
    logic [7:0]       r_s2_x;
    logic             r_s2_bank;
    logic [PIX_W-1:0] r_s2_val;

    logic             r_s3_v;
    logic [7:0]       r_s3_x;
    logic             r_s3_bank;
    logic [PIX_W-1:0] r_s3_val;

    // Readout
    logic             r_rd_pend;
    logic [7:0]       r_rd_addr;
    logic [PIX_W-1:0] r_pix_out;

    // Combinational
    logic             w_run;
    logic             w_swap;
    logic             w_wr_ready;
    logic             w_accept;
    logic             w_rd_fire;
    logic             w_out_fire;
    logic             w_disp_bank;
    logic [PIX_W-1:0] w_existing;
    logic             w_store;
    logic [PIX_W-1:0] w_s1_result;

    // Per-bank RAM ports
    logic [1:0]       w_a_en;
    logic [7:0]       w_a_addr  [2];
    logic [PIX_W-1:0] w_a_rdata [2];
    logic [1:0]       w_b_we;
    logic [7:0]       w_b_addr  [2];
    logic [PIX_W-1:0] w_b_wdata [2];

    assign w_run       = (r_state == ST_RUN);
    // Wrap 511 -> 128 seen as bit 8 falling between consecutive cen samples.
    assign w_swap      = i_cen & r_prev_h256 & ~i_n_h256;
    assign w_wr_ready  = w_run & ~w_swap & ~r_swap_d1;
    assign w_accept    = i_wr_valid & w_wr_ready;
    assign w_rd_fire   = w_run & i_cen & i_n_h256;
    assign w_out_fire  = w_rd_fire & r_rd_pend;
    assign w_disp_bank = ~r_bank_sel;

    assign o_wr_ready  = w_wr_ready;
    assign o_pix_out   = r_pix_out;
    assign o_init_busy = r_init_busy;

    // Resolve the current contents at the S1 location. S2 has not reached the
    // RAM yet; S3 was written on the same edge that the S1 read sampled
    // (read-before-write), so both are newer than the RAM data.
    always_comb begin
        w_existing = w_a_rdata[r_s1_bank];
        if (r_s2_v && (r_s2_x == r_s1_x) && (r_s2_bank == r_s1_bank)) begin
            w_existing = r_s2_val;
        end else if (r_s3_v && (r_s3_x == r_s1_x) && (r_s3_bank == r_s1_bank)) begin
            w_existing = r_s3_val;
        end
        w_store     = (r_s1_pix != TRANSP) && (w_existing == TRANSP);
        w_s1_result = w_store ? r_s1_pix : w_existing;
    end

    // Port steering: the write bank serves the S1 read (A) and S2 write (B);
    // the display bank serves the readout (A) and the clear (B). A draining
    // S2 write after a swap lands on its latched bank ahead of any clear.
    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            w_a_en[b]    = 1'b0;
            w_a_addr[b]  = i_wr_x;
            w_b_we[b]    = 1'b0;
            w_b_addr[b]  = r_sweep;
            w_b_wdata[b] = TRANSP;

            if (1'(b) == r_bank_sel) begin
                w_a_en[b]   = w_accept;
                w_a_addr[b] = i_wr_x;
            end else begin
                w_a_en[b]   = w_rd_fire;
                w_a_addr[b] = i_h_pos;
            end

            if (!w_run) begin
                w_b_we[b]    = 1'b1;
                w_b_addr[b]  = r_sweep;
                w_b_wdata[b] = TRANSP;
            end else if (r_s2_v && r_s2_we && (r_s2_bank == 1'(b))) begin
                w_b_we[b]    = 1'b1;
                w_b_addr[b]  = r_s2_x;
                w_b_wdata[b] = r_s2_val;
            end else if (w_out_fire && (1'(b) == w_disp_bank)) begin
                w_b_we[b]    = 1'b1;
                w_b_addr[b]  = r_rd_addr;
                w_b_wdata[b] = TRANSP;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        linebuf_dpram #(
            .PIX_W  (PIX_W),
            .ADDR_W (LB_ADDR_W)
        ) u_ram (
            .i_clk     (i_clk),
            .i_a_en    (w_a_en[g]),
            .i_a_addr  (w_a_addr[g]),
            .o_a_rdata (w_a_rdata[g]),
            .i_b_we    (w_b_we[g]),
            .i_b_addr  (w_b_addr[g]),
            .i_b_wdata (w_b_wdata[g])
        );
    end

    // Control FSM: clear sweep after reset, then run.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_INIT;
            r_sweep     <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_sweep <= r_sweep + 8'd1;
                    if (r_sweep == 8'hFF) begin
                        r_state     <= ST_RUN;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_init_busy <= 1'b0;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_sweep     <= '0;
                    r_init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Swap tracking, write pipeline and readout sequencing.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bank_sel  <= 1'b0;
            r_prev_h256 <= 1'b0;
            r_swap_d1   <= 1'b0;
            r_s1_v      <= 1'b0;
            r_s1_x      <= '0;
            r_s1_pix    <= TRANSP;
            r_s1_bank   <= 1'b0;
            r_s2_v      <= 1'b0;
            r_s2_we     <= 1'b0;
            r_s2_x      <= '0;
            r_s2_bank   <= 1'b0;
            r_s2_val    <= TRANSP;
            r_s3_v      <= 1'b0;
            r_s3_x      <= '0;
            r_s3_bank   <= 1'b0;
            r_s3_val    <= TRANSP;
            r_rd_pend   <= 1'b0;
            r_rd_addr   <= '0;
            r_pix_out   <= TRANSP;
        end else begin
            r_swap_d1 <= w_swap;
            if (w_swap) begin
                r_bank_sel <= ~r_bank_sel;
            end
            if (i_cen) begin
                r_prev_h256 <= i_n_h256;
            end

            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_x    <= i_wr_x;
                r_s1_pix  <= i_wr_pix;
                r_s1_bank <= r_bank_sel;
            end

            r_s2_v    <= r_s1_v;
            r_s2_we   <= r_s1_v & w_store;
            r_s2_x    <= r_s1_x;
            r_s2_bank <= r_s1_bank;
            r_s2_val  <= w_s1_result;

            r_s3_v    <= r_s2_v;
            r_s3_x    <= r_s2_x;
            r_s3_bank <= r_s2_bank;
            r_s3_val  <= r_s2_val;

            if (i_cen) begin
                if (w_out_fire) begin
                    r_pix_out <= w_a_rdata[w_disp_bank];
                end else begin
                    r_pix_out <= TRANSP;
                end
                r_rd_pend <= w_rd_fire;
                if (w_rd_fire) begin
                    r_rd_addr <= i_h_pos;
                end
            end
        end
    end

endmodule

// File: tb/tb_tp84_sprite_linebuf.sv
// -----------------------------------------------------------------------------
// tb_tp84_sprite_linebuf
// Drives a free-running 128..511 horizontal counter with cen on every other
// clk, issues sprite writes, and compares pix_out against a line-level model
// through a scoreboard queue. wr_ready and init_busy are checked every clk.
// -----------------------------------------------------------------------------
module tb_tp84_sprite_linebuf;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic [7:0] h_pos;
    logic       n_h256;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_x;
    logic [7:0] wr_pix;
    logic [7:0] pix_out;
    logic       init_busy;

    always #5 clk = ~clk;

    tp84_sprite_linebuf #(
        .PIX_W  (8),
        .TRANSP (8'h00)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_cen       (cen),
        .i_h_pos     (h_pos),
        .i_n_h256    (n_h256),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_x      (wr_x),
        .i_wr_pix    (wr_pix),
        .o_pix_out   (pix_out),
        .o_init_busy (init_busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;

    // Line model: two banks, write-bank select, readout pending state.
    logic [7:0]  mb [2][256];
    logic        msel;
    logic        mprev;
    logic        mpend;
    logic        mswap_d;
    logic [7:0]  mrd;
    int unsigned init_cnt;
    logic [8:0]  h_cnt;
    logic [7:0]  sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++)
                mb[b][a] = 8'h00;
        msel     = 1'b0;
        mprev    = 1'b0;
        mpend    = 1'b0;
        mswap_d  = 1'b0;
        mrd      = 8'h00;
        init_cnt = 0;
    endtask

    // One clk: called just after a negedge with inputs set.
    task automatic step();
        logic       swap_now;
        logic       exp_ready;
        logic       in_run;
        logic       pushed;
        logic [7:0] e;
        pushed = 1'b0;
        #1;
        if (rst) begin
            model_reset();
            sb_q.push_back(8'h00);
            pushed = 1'b1;
        end else begin
            in_run    = (init_cnt >= 256);
            swap_now  = cen && mprev && !n_h256;
            exp_ready = in_run && !swap_now && !mswap_d;
            check_eq("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
            check_eq("init_busy", {31'd0, init_busy}, {31'd0, !in_run});
            if (wr_valid && exp_ready && wr_pix != 8'h00 && mb[msel][wr_x] == 8'h00)
                mb[msel][wr_x] = wr_pix;
            if (cen) begin
                e = 8'h00;
                if (in_run && n_h256 && mpend) begin
                    e = mb[!msel][mrd];
                    mb[!msel][mrd] = 8'h00;
                end
                sb_q.push_back(e);
                pushed = 1'b1;
                mpend  = in_run && n_h256;
                if (n_h256) mrd = h_pos;
                mprev = n_h256;
            end
            if (swap_now) msel = !msel;
            mswap_d = swap_now;
            if (init_cnt < 256) init_cnt++;
        end
        @(posedge clk);
        #1;
        if (pushed) begin
            e = sb_q.pop_front();
            check_eq($sformatf("pix_out h=%0d", h_cnt), {24'd0, pix_out}, {24'd0, e});
        end
        if (cen) h_cnt = (h_cnt == 9'd511) ? 9'd128 : h_cnt + 9'd1;
        @(negedge clk);
        cen    = !cen;
        h_pos  = h_cnt[7:0];
        n_h256 = h_cnt[8];
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance to the cen cycle at counter value target (bounded).
    task automatic wait_h(input logic [8:0] target);
        for (int i = 0; i < 2000 && !(cen && h_cnt == target); i++) step();
        check_eq("wait_h", {22'd0, cen, h_cnt}, {22'd0, 1'b1, target});
    endtask

    task automatic write(input logic [7:0] x, input logic [7:0] p);
        wr_valid = 1'b1;
        wr_x     = x;
        wr_pix   = p;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        cen      = 1'b0;
        h_cnt    = 9'd128;
        h_pos    = h_cnt[7:0];
        n_h256   = h_cnt[8];
        wr_valid = 1'b0;
        wr_x     = 8'h00;
        wr_pix   = 8'h00;
        model_reset();
        @(negedge clk);
        steps(2);
        rst = 1'b0;

        // Write request held through INIT; transparent so nothing lands.
        wr_valid = 1'b1;
        wr_x     = 8'd3;
        wr_pix   = 8'h00;
        steps(258);
        wr_valid = 1'b0;

        // Two lines of all-transparent display.
        steps(2 * 768);

        // Forwarding, priority and transparent-write cases in the write bank.
        wait_h(9'd200);
        write(8'd10, 8'h21);
        write(8'd10, 8'h35);
        write(8'd5, 8'h44);
        write(8'd20, 8'h11);
        step();
        write(8'd20, 8'h22);
        write(8'd200, 8'h7F);
        write(8'd5, 8'h00);
        steps(3);
        write(8'd5, 8'h66);
        write(8'd30, 8'h50);
        write(8'd31, 8'h51);
        write(8'd30, 8'h52);
        steps(3 * 768);

        // Writes held across the bank swap.
        wait_h(9'd511);
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_x     = 8'd60 + 8'(i);
            wr_pix   = 8'h60 + 8'(i);
            step();
        end
        wr_valid = 1'b0;
        steps(3 * 768);

        // Reset in the middle of a visible line with pixels pending.
        wait_h(9'd150);
        write(8'd100, 8'h33);
        write(8'd128, 8'h44);
        write(8'd140, 8'h45);
        wait_h(9'd300);
        write(8'd40, 8'h55);
        wait_h(9'd384);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(256 + 3 * 768);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
